// File: rtl/div_fu_sequencer_if.sv
// Shared types and the issue/flush/CDB interface of the divide functional unit.
// Package: branch_tag_t (sign bit + one-hot-ish tag mask) used for flush matching.
// Interface signals:
//   issue, operand1, operand2, div_op_type, div_signed, br_tag_in, dest_ROB_in : RS -> FU
//   FU_running                                                                  : FU -> RS
//   flush, flush_tag                                                            : branch unit -> FU
//   cdb_req, cdb_rd_v, cdb_dest_ROB, busy_cycles                                : FU -> CDB / debug
//   cdb_grant                                                                   : CDB arbiter -> FU
// Modports: master (RS / CDB / branch side), slave (the divide unit).
package div_fu_sequencer_pkg;
  localparam int unsigned BR_TAG_W = 4;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;
endpackage

interface div_fu_sequencer_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_WIDTH = 3
);
  import div_fu_sequencer_pkg::*;

  logic                 issue;
  logic [XLEN-1:0]      operand1;
  logic [XLEN-1:0]      operand2;
  logic                 div_op_type;
  logic                 div_signed;
  branch_tag_t          br_tag_in;
  logic [ROB_WIDTH-1:0] dest_ROB_in;
  logic                 FU_running;
  logic                 flush;
  branch_tag_t          flush_tag;
  logic                 cdb_req;
  logic                 cdb_grant;
  logic [XLEN-1:0]      cdb_rd_v;
  logic [ROB_WIDTH-1:0] cdb_dest_ROB;
  logic [5:0]           busy_cycles;

  modport master (
    output issue, operand1, operand2, div_op_type, div_signed, br_tag_in, dest_ROB_in,
    output flush, flush_tag, cdb_grant,
    input  FU_running, cdb_req, cdb_rd_v, cdb_dest_ROB, busy_cycles
  );

  modport slave (
    input  issue, operand1, operand2, div_op_type, div_signed, br_tag_in, dest_ROB_in,
    input  flush, flush_tag, cdb_grant,
    output FU_running, cdb_req, cdb_rd_v, cdb_dest_ROB, busy_cycles
  );
endinterface

// File: rtl/div_fu_sequencer.sv
// Shared divide functional unit: accepts one issued divide, runs an XLEN-step
// radix-2 restoring division with RV32M sign / divide-by-zero rules, then holds
// the result on the CDB request until granted. Squashes work on a matching flush.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_fu_sequencer_if.slave (issue, flush and CDB signals)
module div_fu_sequencer
  import div_fu_sequencer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned XLEN      = 32
) (
  input logic                clk,
  input logic                rst,
  div_fu_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    FIX      = 2'd2,
    WAIT_CDB = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      quo_q, quo_d;       // dividend shifts out as quotient shifts in
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      divisor_q, divisor_d;
  logic [XLEN-1:0]      orig_a_q, orig_a_d;
  logic                 op_q, op_d;
  logic                 sgn_q, sgn_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dbz_q, dbz_d;
  branch_tag_t          tag_q, tag_d;
  logic [ROB_WIDTH-1:0] rob_q, rob_d;
  logic [CNT_W-1:0]     busy_q, busy_d;
  logic [XLEN-1:0]      rd_v_q, rd_v_d;
  logic [ROB_WIDTH-1:0] dest_q, dest_d;

  logic [XLEN:0]        rem_shift;
  logic [XLEN:0]        rem_trial;
  logic [XLEN-1:0]      abs_a, abs_b, res_quo, res_rem;
  logic                 a_neg, b_neg;
  logic                 kill_held, kill_issue;

  // Same-sign tags die when they contain the flush mask; a tag on the other
  // side of a sign flip dies when it is contained in the flush mask.
  function automatic logic kill_f(input branch_tag_t t, input logic fl, input branch_tag_t ft);
    logic hit;
    if (t.sign == ft.sign) hit = ((t.tag & ft.tag) == ft.tag);
    else                   hit = ((t.tag & ft.tag) == t.tag);
    return fl && hit;
  endfunction

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    orig_a_d  = orig_a_q;
    op_d      = op_q;
    sgn_d     = sgn_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dbz_d     = dbz_q;
    tag_d     = tag_q;
    rob_d     = rob_q;
    busy_d    = busy_q;
    rd_v_d    = rd_v_q;
    dest_d    = dest_q;

    kill_held  = kill_f(tag_q, bus.flush, bus.flush_tag);
    kill_issue = kill_f(bus.br_tag_in, bus.flush, bus.flush_tag);

    a_neg = bus.div_signed && bus.operand1[XLEN-1];
    b_neg = bus.div_signed && bus.operand2[XLEN-1];
    abs_a = a_neg ? (~bus.operand1 + XLEN'(1)) : bus.operand1;
    abs_b = b_neg ? (~bus.operand2 + XLEN'(1)) : bus.operand2;

    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_trial = rem_shift - {1'b0, divisor_q};

    if (dbz_q) begin
      res_quo = '1;
      res_rem = orig_a_q;
    end else begin
      res_quo = (sgn_q && neg_q_q) ? (~quo_q + XLEN'(1)) : quo_q;
      res_rem = (sgn_q && neg_r_q) ? (~rem_q + XLEN'(1)) : rem_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.issue && !kill_issue) begin
          quo_d     = abs_a;
          divisor_d = abs_b;
          orig_a_d  = bus.operand1;
          op_d      = bus.div_op_type;
          sgn_d     = bus.div_signed;
          neg_q_d   = a_neg ^ b_neg;
          neg_r_d   = a_neg;
          tag_d     = bus.br_tag_in;
          rob_d     = bus.dest_ROB_in;
          rem_d     = '0;
          busy_d    = '0;
          dbz_d     = (bus.operand2 == '0);
          state_d   = (bus.operand2 == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (kill_held) begin
          state_d = IDLE;
        end else begin
          // Restore by keeping the shifted remainder when the trial goes negative
          rem_d  = rem_trial[XLEN] ? rem_shift[XLEN-1:0] : rem_trial[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], ~rem_trial[XLEN]};
          busy_d = busy_q + CNT_W'(1);
          if (busy_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (kill_held) begin
          state_d = IDLE;
        end else begin
          rd_v_d  = op_q ? res_rem : res_quo;
          dest_d  = rob_q;
          state_d = WAIT_CDB;
        end
      end
      WAIT_CDB: begin
        if (kill_held || bus.cdb_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      orig_a_q  <= '0;
      op_q      <= 1'b0;
      sgn_q     <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dbz_q     <= 1'b0;
      tag_q     <= '0;
      rob_q     <= '0;
      busy_q    <= '0;
      rd_v_q    <= '0;
      dest_q    <= '0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      orig_a_q  <= orig_a_d;
      op_q      <= op_d;
      sgn_q     <= sgn_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dbz_q     <= dbz_d;
      tag_q     <= tag_d;
      rob_q     <= rob_d;
      busy_q    <= busy_d;
      rd_v_q    <= rd_v_d;
      dest_q    <= dest_d;
    end
  end

  assign bus.FU_running   = (state_q != IDLE);
  assign bus.cdb_req      = (state_q == WAIT_CDB) && !kill_held;
  assign bus.cdb_rd_v     = rd_v_q;
  assign bus.cdb_dest_ROB = dest_q;
  assign bus.busy_cycles  = busy_q;

endmodule
